// File: rtl/bus_pkg.sv
// Shared definitions for the CPU data-bus return path: slave indices,
// response-FSM state encoding and the default bus-error read value.
package bus_pkg;

  localparam int unsigned N_SLV = 4;

  localparam logic [1:0] SLV_IMEM = 2'd0;
  localparam logic [1:0] SLV_DMEM = 2'd1;
  localparam logic [1:0] SLV_UART = 2'd2;
  localparam logic [1:0] SLV_GPIO = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/onehot_check.sv
// Flags whether the decoder select vector names exactly one slave and, if so,
// which one, so the router can reject unmapped and multiply-decoded addresses.
module onehot_check
  import bus_pkg::*;
(
  input  logic [N_SLV-1:0] vec_i,
  output logic             is_onehot_o,
  output logic [1:0]       index_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    is_onehot_o = 1'b0;
    index_o     = SLV_IMEM;
    case (vec_i)
      4'b0001: begin is_onehot_o = 1'b1; index_o = SLV_IMEM; end
      4'b0010: begin is_onehot_o = 1'b1; index_o = SLV_DMEM; end
      4'b0100: begin is_onehot_o = 1'b1; index_o = SLV_UART; end
      4'b1000: begin is_onehot_o = 1'b1; index_o = SLV_GPIO; end
      default: begin is_onehot_o = 1'b0; index_o = SLV_IMEM; end
    endcase
  end

endmodule

// File: rtl/bus_response_router.sv
// Tracks the single outstanding CPU bus transaction: strobes the decoded slave,
// waits for its ready (with a hang timeout) and returns data or a bus error.
module bus_response_router
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [N_SLV-1:0]    sel_vec,
  input  logic [N_SLV-1:0]    slv_ready,
  input  logic [N_SLV*32-1:0] slv_rdata,
  output logic [N_SLV-1:0]    slv_req,
  output logic                slv_we,
  output logic [31:0]         cpu_rdata,
  output logic                cpu_ack,
  output logic                cpu_err,
  output logic                busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [N_SLV-1:0] sel_q, sel_d;
  logic             we_q, we_d;
  logic [1:0]       idx_q, idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             sel_onehot;
  logic [1:0]       sel_index;

  onehot_check u_onehot_check (
    .vec_i       (sel_vec),
    .is_onehot_o (sel_onehot),
    .index_o     (sel_index)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (sel_onehot) begin
            sel_d   = sel_vec;
            we_d    = cpu_we;
            idx_d   = sel_index;
            timer_d = '0;
            state_d = S_WAIT;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_WAIT: begin
        // Ready is checked before the timeout so a last-cycle ready still completes.
        if (|(slv_ready & sel_q)) begin
          rdata_d = we_q ? 32'h0 : slv_rdata[{idx_q, 5'b0} +: 32];
          state_d = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= SLV_IMEM;
      timer_q <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are decoded from registered state only, so they are glitch-free.
  assign slv_req   = (state_q == S_WAIT) ? sel_q : '0;
  assign slv_we    = (state_q == S_WAIT) && we_q;
  assign cpu_ack   = (state_q == S_RESP) || (state_q == S_ERR);
  assign cpu_err   = (state_q == S_ERR);
  assign busy      = (state_q != S_IDLE);
  assign cpu_rdata = (state_q == S_RESP) ? rdata_q :
                     (state_q == S_ERR)  ? ERR_RDATA : 32'h0;

endmodule
